reg_file_param: RTL

Parametrised multi-port register file for the processor datapath. Holds DEPTH words of WIDTH bits with one write port and NUM_RD combinational read ports, an optional hard-wired zero register, optional write-to-read bypass, and a sequential clear sweep. It sits between the instruction decoder (addresses, write enable) and the ALU operand muxes.

---
 rtl/reg_file_pkg.sv | 18 +
 rtl/reg_file_word.sv | 24 ++
 rtl/reg_file_param.sv | 125 ++++++++++++
 3 files changed

// File: rtl/reg_file_pkg.sv
// Shared types and helpers for the parametrised register file.
package reg_file_pkg;

  // Clear-sweep controller states.
  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_SWEEP = 1'b1
  } rf_state_t;

  // True when an address names a real, writable/readable storage word:
  // inside the implemented depth and not the hard-wired zero register.
  function automatic logic addr_usable(input int unsigned addr,
                                       input int unsigned depth,
                                       input logic        zero_reg);
    return (addr < depth) && !(zero_reg && (addr == 0));
  endfunction

endpackage

// File: rtl/reg_file_word.sv
// One storage word: synchronous reset, synchronous clear, write enable.
module reg_file_word #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clr_i,
  input  logic             we_i,
  input  logic [WIDTH-1:0] d_i,
  output logic [WIDTH-1:0] q_o
);

  // Reset and sweep-clear take priority over a write to the same word.
  always_ff @(posedge clk) begin
    if (reset) begin
      q_o <= '0;
    end else if (clr_i) begin
      q_o <= '0;
    end else if (we_i) begin
      q_o <= d_i;
    end
  end

endmodule

// File: rtl/reg_file_param.sv
// Parametrised register file: one write port, NUM_RD combinational read
// ports, optional zero register, optional write-to-read bypass and a
// sequential clear sweep.
//
// Clear request protocol: clear_i is a single-cycle request sampled at a
// rising edge while busy_o is low; the sweep then runs for exactly DEPTH
// cycles with busy_o high. Requests seen while busy_o is high are ignored,
// and writes presented while busy_o is high are dropped (wr_err_o flags it).
module reg_file_param
  import reg_file_pkg::*;
#(
  parameter int WIDTH    = 32,
  parameter int DEPTH    = 32,
  parameter int NUM_RD   = 2,
  parameter int ZERO_REG = 1,
  parameter int BYPASS   = 1,
  // Derived from DEPTH; leave at its default.
  parameter int ADDR_W   = $clog2(DEPTH)
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     wr_en_i,
  input  logic [ADDR_W-1:0]        wr_addr_i,
  input  logic [WIDTH-1:0]         wr_data_i,
  input  logic [NUM_RD*ADDR_W-1:0] rd_addr_i,
  output logic [NUM_RD*WIDTH-1:0]  rd_data_o,
  input  logic                     clear_i,
  output logic                     busy_o,
  output logic                     wr_err_o
);

  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);
  localparam logic              HAS_ZERO  = (ZERO_REG != 0);

  rf_state_t         state;
  logic [ADDR_W-1:0] ptr;
  logic              wr_accept;
  logic [WIDTH-1:0]  word_q [DEPTH];

  // A write lands only when idle and aimed at a real, non-zero-register word.
  assign wr_accept = wr_en_i && (state == ST_IDLE) &&
                     addr_usable(32'(wr_addr_i), 32'(DEPTH), HAS_ZERO);

  // Storage words with per-word write select and sweep clear.
  for (genvar j = 0; j < DEPTH; j++) begin : g_word
    logic wr_sel;
    logic sweep_clr;
    assign wr_sel    = wr_accept && (wr_addr_i == ADDR_W'(j));
    assign sweep_clr = (state == ST_SWEEP) && (ptr == ADDR_W'(j));

    reg_file_word #(.WIDTH(WIDTH)) u_word (
      .clk   (clk),
      .reset (reset),
      .clr_i (sweep_clr),
      .we_i  (wr_sel),
      .d_i   (wr_data_i),
      .q_o   (word_q[j])
    );
  end

  // Read ports: out-of-range and zero register read 0, bypass beats storage.
  for (genvar k = 0; k < NUM_RD; k++) begin : g_rd
    logic [ADDR_W-1:0] addr;
    logic [WIDTH-1:0]  stored;
    logic [WIDTH-1:0]  data;

    assign addr = rd_addr_i[k*ADDR_W +: ADDR_W];

    // Explicit compare mux keeps out-of-range addresses away from the array.
    always_comb begin
      stored = '0;
      for (int j = 0; j < DEPTH; j++) begin
        if (addr == ADDR_W'(j)) stored = word_q[j];
      end
    end

    // Final port value; wr_accept is already low during a sweep.
    always_comb begin
      if (!addr_usable(32'(addr), 32'(DEPTH), HAS_ZERO)) begin
        data = '0;
      end else if ((BYPASS != 0) && wr_accept && (addr == wr_addr_i)) begin
        data = wr_data_i;
      end else begin
        data = stored;
      end
    end

    assign rd_data_o[k*WIDTH +: WIDTH] = data;
  end

  // Sweep controller with registered busy flag and dropped-write flag.
  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= ST_IDLE;
      ptr      <= '0;
      busy_o   <= 1'b0;
      wr_err_o <= 1'b0;
    end else begin
      wr_err_o <= wr_en_i && !wr_accept;
      case (state)
        ST_IDLE: begin
          if (clear_i) begin
            state  <= ST_SWEEP;
            ptr    <= '0;
            busy_o <= 1'b1;
          end
        end
        ST_SWEEP: begin
          if (ptr == LAST_ADDR) begin
            state  <= ST_IDLE;
            ptr    <= '0;
            busy_o <= 1'b0;
          end else begin
            ptr <= ptr + ADDR_W'(1);
          end
        end
        default: begin
          state  <= ST_IDLE;
          busy_o <= 1'b0;
        end
      endcase
    end
  end

endmodule
